uart_tx_fsm: RTL
================

# uart_tx_fsm

Frame-sequencing controller for the UART transmitter. It accepts a byte handshake from upstream, enables the serializer for exactly the data bits, and computes and holds the parity bit. It also drives the line bit on TX_OUT: start, data, parity, stop. It sits between the register-file/FIFO side and the serializer, and TX_OUT is the UART_TX pin.

## Interface
- WIDTH, 8, data bits per frame; must match the serializer's WIDTH.
- CLK  in  1  transmit clock (UART TX clock domain).
- RST  in  1  synchronous, active-high reset.
- P_DATA  in  WIDTH  byte to send; valid with DATA_VALID.
- DATA_VALID  in  1  single-cycle request; accepted only when READY=1.
- PAR_EN  in  1  1 = insert parity bit; sampled at accept.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled at accept.
- SER_DATA  in  1  registered serial bit from the serializer.
- SER_DONE  in  1  serializer counter exhausted.
- SER_EN  out  1  serializer shift enable.
- TX_OUT  out  1  UART line; idle high.
- BUSY  out  1  frame in progress (START..STOP).
- READY  out  1  new DATA_VALID may be issued this cycle (IDLE or STOP).
- SYNC_ERR  out  1  one-cycle pulse: serializer failed to finish within WIDTH data cycles.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encoding is free; the state register is the only source of output decode.
- Accept = DATA_VALID & READY. On accept:
  - Latch par_bit = ^P_DATA when PAR_TYP=0, or ~^P_DATA when PAR_TYP=1.
  - Latch par_en_q = PAR_EN.
  - Next state is START.
- The serializer captures P_DATA on the same DATA_VALID; this block does not store the byte.
- IDLE: TX_OUT=1, BUSY=0, READY=1, SER_EN=0. Stays in IDLE until accept.
- START: TX_OUT=0, BUSY=1, SER_EN=1 (preloads the MSB into SER_DATA). Next state is DATA; clear the data-cycle counter dcnt to 1.
- DATA: TX_OUT=SER_DATA, BUSY=1, SER_EN = ~SER_DONE, dcnt increments each cycle.
  - If SER_DONE=1: go to PARITY when par_en_q=1, otherwise STOP.
  - Else if dcnt==WIDTH: pulse SYNC_ERR for one cycle and go to STOP (skip parity).
- PARITY: TX_OUT=par_bit, BUSY=1, SER_EN=0. Next state is STOP.
- STOP: TX_OUT=1, BUSY=1, READY=1, SER_EN=0.
  - On accept: go directly to START with the new parity latched (back-to-back frames, no idle bit).
  - Otherwise: go to IDLE.
- DATA_VALID while READY=0 is a protocol violation. The controller ignores it; the bench flags it as an error.
- Bit order on TX_OUT is MSB first, as the serializer produces.
- dcnt width is clog2(WIDTH)+1 bits and does not wrap within a frame.

## Timing
- Reset (RST=1 at a CLK edge): state=IDLE, par_bit=0, par_en_q=0, dcnt=0.
  - Outputs after that edge: TX_OUT=1, SER_EN=0, BUSY=0, READY=1, SER_ERR absent, SYNC_ERR=0.
- Reset mid-frame: the line returns to 1 on the cycle after the reset edge. No stop bit is emitted.
- Outputs are combinational decodes of registered state, par_bit and SER_DATA only. No combinational path exists from DATA_VALID, P_DATA or PAR_* to any output, except READY-independent SER_EN, which depends on SER_DONE.
- Latency: accept at edge N gives TX_OUT=0 in cycle N+1.
- Frame length is 2+WIDTH+par_en_q cycles.
  - START: 1 cycle.
  - DATA: exactly WIDTH cycles with a conforming serializer.
  - PARITY: 0 or 1 cycle.
  - STOP: 1 cycle.
- SER_EN is high for exactly WIDTH cycles per frame: START plus the first WIDTH-1 DATA cycles.
- SER_DONE rises in DATA cycle WIDTH.
- SYNC_ERR is asserted in the cycle DATA exits with dcnt==WIDTH and SER_DONE=0.
- Back-to-back frames: continuous period of 2+WIDTH+par_en cycles; TX_OUT goes STOP→START with no extra high cycle.

## Test plan
- Reset then idle 20 cycles → TX_OUT=1, BUSY=0, READY=1, SER_EN=0 throughout.
- 0xA5, PAR_EN=1, PAR_TYP=0 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles. Parity is 0. BUSY is high for 11 cycles. SER_EN is high for 8 cycles starting at START.
- 0xA5, PAR_EN=1, PAR_TYP=1 → parity bit 1. 0x00, PAR_EN=0 → 0, eight 0s, 1 over 10 cycles, with no PARITY state.
- 0x3C accepted, then 0xFF issued during STOP with PAR_EN=0 → START immediately follows STOP. The second frame is 0,1×8,1. No idle cycle and no SYNC_ERR.
- RST pulsed in DATA cycle 4 of 0x81 → next cycle TX_OUT=1, BUSY=0, READY=1. A following 0x55 frame is correct.
- Serializer stub holding SER_DONE=0 → after 8 DATA cycles, SYNC_ERR pulses once and the state goes to STOP (PARITY skipped). DATA_VALID pulsed while in DATA is ignored.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start, data, optional parity and stop bits.
// Drives the line and the serializer enable, and flags a serializer that runs long.
module uart_tx_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             SER_DATA,
    input  logic             SER_DONE,
    output logic             SER_EN,
    output logic             TX_OUT,
    output logic             BUSY,
    output logic             READY,
    output logic             SYNC_ERR
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic             par_bit_q, par_bit_d;
    logic             par_en_q,  par_en_d;
    logic [CNT_W-1:0] dcnt_q,    dcnt_d;
    logic             accept;
    logic             data_last;

    // Even parity makes the total count of ones even; odd parity inverts it.
    function automatic logic calc_parity(input logic [WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign accept    = DATA_VALID & READY;
    assign data_last = (dcnt_q == CNT_W'(WIDTH));

    always_comb begin
        SER_EN   = 1'b0;
        TX_OUT   = 1'b1;
        BUSY     = 1'b0;
        READY    = 1'b0;
        SYNC_ERR = 1'b0;
        case (state_q)
            S_IDLE: begin
                READY = 1'b1;
            end
            S_START: begin
                TX_OUT = 1'b0;
                BUSY   = 1'b1;
                SER_EN = 1'b1;
            end
            S_DATA: begin
                TX_OUT   = SER_DATA;
                BUSY     = 1'b1;
                SER_EN   = ~SER_DONE;
                SYNC_ERR = ~SER_DONE & data_last;
            end
            S_PARITY: begin
                TX_OUT = par_bit_q;
                BUSY   = 1'b1;
            end
            S_STOP: begin
                BUSY  = 1'b1;
                READY = 1'b1;
            end
            default: begin
                READY = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        dcnt_d    = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_DATA;
                dcnt_d  = CNT_W'(1);
            end
            S_DATA: begin
                dcnt_d = dcnt_q + CNT_W'(1);
                if (SER_DONE) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else if (data_last) begin
                    state_d = S_STOP;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                state_d = accept ? S_START : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Parity settings are captured with the byte so a frame is self-consistent.
        if (accept) begin
            par_bit_d = calc_parity(P_DATA, PAR_TYP);
            par_en_d  = PAR_EN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            dcnt_q    <= dcnt_d;
        end
    end

endmodule
